// File: rtl/rkey_add_stage.sv
// Registered AddRoundKey stage of the iterative AES-128 decryption datapath; 1-cycle latency, one-entry skid.
// in_ready is the inverted skid-full flop, so out_ready never reaches it combinationally. Optional: RKEY_ADD_STAGE_STAT_EN.
module rkey_add_stage #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_first,
    input  logic [31:0]   in_row1,
    input  logic [31:0]   in_row2,
    input  logic [31:0]   in_row3,
    input  logic [31:0]   in_row4,
    output logic [RW-1:0] rk_idx,
    input  logic [127:0]  rkey,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_row1,
    output logic [31:0]   out_row2,
    output logic [31:0]   out_row3,
    output logic [31:0]   out_row4,
    output logic [RW-1:0] out_round,
    output logic          out_last,
    output logic          seq_err
`ifdef RKEY_ADD_STAGE_STAT_EN
    ,
    output logic [15:0]   blk_cnt
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [3:0][31:0] rows;
        logic [RW-1:0]    round;
        logic             last;
    } beat_t;

    state_t        state, state_n;
    logic [RW-1:0] rc, rc_n;
    logic          accept, produce, err_evt;
    logic [3:0][31:0] in_rows;
    beat_t         beat, out_q, skid_q;
    logic          out_vld, skid_vld;

    assign accept  = in_valid & in_ready;
    assign in_rows = {in_row4, in_row3, in_row2, in_row1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rc    <= '0;
        end else begin
            state <= state_n;
            rc    <= rc_n;
        end
    end

    always_comb begin
        state_n = state;
        rc_n    = rc;
        if (accept) begin
            if (in_first) begin
                if (NR > 0) begin
                    state_n = RUN;
                    rc_n    = RW'(NR - 1);
                end else begin
                    state_n = IDLE;
                end
            end else if (state == RUN) begin
                if (rc == '0) state_n = IDLE;
                else          rc_n    = rc - 1'b1;
            end
        end
    end

    // A first beat always restarts at round NR; a non-first beat in IDLE is swallowed.
    always_comb begin
        rk_idx     = (state == RUN) ? rc : RW'(NR);
        produce    = accept & (in_first | (state == RUN));
        err_evt    = accept & ((in_first & (state == RUN)) | (!in_first & (state == IDLE)));
        beat.round = in_first ? RW'(NR) : rc;
        beat.last  = (beat.round == '0);
        beat.rows  = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                beat.rows[r][31-8*c -: 8] = in_rows[r][31-8*c -: 8] ^ rkey[127-32*c-8*r -: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q    <= '0;
            skid_q   <= '0;
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            seq_err  <= 1'b0;
        end else begin
            seq_err <= seq_err | err_evt;
            if (skid_vld) begin
                if (out_ready) begin
                    out_q    <= skid_q;
                    skid_vld <= 1'b0;
                end
            end else if (produce) begin
                if (!out_vld || out_ready) begin
                    out_q   <= beat;
                    out_vld <= 1'b1;
                end else begin
                    skid_q   <= beat;
                    skid_vld <= 1'b1;
                end
            end else if (out_vld && out_ready) begin
                out_vld <= 1'b0;
            end
        end
    end

`ifdef RKEY_ADD_STAGE_STAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt <= '0;
        end else if (out_vld && out_ready && out_q.last && (blk_cnt != 16'hFFFF)) begin
            blk_cnt <= blk_cnt + 16'd1;
        end
    end
`endif

    assign in_ready  = ~skid_vld;
    assign out_valid = out_vld;
    assign out_row1  = out_q.rows[0];
    assign out_row2  = out_q.rows[1];
    assign out_row3  = out_q.rows[2];
    assign out_row4  = out_q.rows[3];
    assign out_round = out_q.round;
    assign out_last  = out_q.last;

endmodule

// File: tb/tb_rkey_add_stage.sv
// Bench for rkey_add_stage: queue-based reference model plus directed literal checks.
module tb_rkey_add_stage;
    localparam int NR = 10;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_first;
    logic [31:0]   in_row1, in_row2, in_row3, in_row4;
    logic [RW-1:0] rk_idx;
    logic [127:0]  rkey;
    logic          out_valid, out_ready;
    logic [31:0]   out_row1, out_row2, out_row3, out_row4;
    logic [RW-1:0] out_round;
    logic          out_last, seq_err;
`ifdef RKEY_ADD_STAGE_STAT_EN
    logic [15:0]   blk_cnt;
`endif

    always #5 clk = ~clk;

    logic [127:0] keys [16];
    assign rkey = keys[rk_idx];

    rkey_add_stage #(.NR(NR), .RW(RW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
        .in_row1(in_row1), .in_row2(in_row2), .in_row3(in_row3), .in_row4(in_row4),
        .rk_idx(rk_idx), .rkey(rkey),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_row1(out_row1), .out_row2(out_row2), .out_row3(out_row3), .out_row4(out_row4),
        .out_round(out_round), .out_last(out_last), .seq_err(seq_err)
`ifdef RKEY_ADD_STAGE_STAT_EN
        , .blk_cnt(blk_cnt)
`endif
    );

    typedef struct {
        logic [127:0] rows;   // row1 in the top word
        int           rnd;
    } exp_t;

    exp_t q[$];
    int   m_pos;      // next round of the open block, -1 when no block is open
    bit   m_err;
    int   m_blk;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Row R column C is XORed with key byte at column C, row R of the column-major key.
    function automatic logic [31:0] xrow(input logic [31:0] row, input logic [127:0] k, input int r);
        logic [31:0] res;
        for (int c = 0; c < 4; c++)
            res[31-8*c -: 8] = row[31-8*c -: 8] ^ k[127-32*c-8*r -: 8];
        return res;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pos = -1;
        m_err = 1'b0;
        m_blk = 0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_first = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        #2;
        model_reset();
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    // One cycle: drive, compare every output with the model, advance model for this edge.
    task automatic step(input bit v, input bit f, input bit ordy,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d);
        exp_t e;
        bit   acc;
        int   idx, rnd;
        in_valid = v; in_first = f; out_ready = ordy;
        in_row1 = a; in_row2 = b; in_row3 = c; in_row4 = d;
        #1;
        idx = (m_pos < 0) ? NR : m_pos;
        acc = v && (q.size() < 2);
        chk("rk_idx", 128'(rk_idx), 128'(idx));
        chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
        chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
        chk("seq_err", 128'(seq_err), 128'(m_err));
`ifdef RKEY_ADD_STAGE_STAT_EN
        chk("blk_cnt", 128'(blk_cnt), 128'(m_blk));
`endif
        if (q.size() > 0) begin
            e = q[0];
            chk("out_rows", {out_row1, out_row2, out_row3, out_row4}, e.rows);
            chk("out_round", 128'(out_round), 128'(e.rnd));
            chk("out_last", 128'(out_last), 128'(e.rnd == 0));
            if (ordy) begin
                void'(q.pop_front());
                if (e.rnd == 0 && m_blk < 16'hFFFF) m_blk++;
            end
        end
        if (acc) begin
            rnd = -1;
            if (f) begin
                if (m_pos >= 0) m_err = 1'b1;
                rnd = NR;
                m_pos = NR - 1;
            end else if (m_pos < 0) begin
                m_err = 1'b1;
            end else begin
                rnd = m_pos;
                m_pos = m_pos - 1;
            end
            if (rnd >= 0) begin
                e.rows = {xrow(a, keys[idx], 0), xrow(b, keys[idx], 1),
                          xrow(c, keys[idx], 2), xrow(d, keys[idx], 3)};
                e.rnd = rnd;
                q.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rstep(input bit v, input bit f, input bit ordy);
        step(v, f, ordy, $urandom(), $urandom(), $urandom(), $urandom());
    endtask

    task automatic finish_block();
        for (int i = 0; i < 40 && m_pos >= 0; i++) rstep(1'b1, 1'b0, 1'b1);
        rstep(1'b0, 1'b0, 1'b1);
        rstep(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_first = 1'b0; out_ready = 1'b0;
        in_row1 = '0; in_row2 = '0; in_row3 = '0; in_row4 = '0;
        for (int i = 0; i < 16; i++) keys[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        keys[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        @(negedge clk);
        do_reset();
        chk("reset_round", 128'(out_round), 128'(0));
        chk("reset_last", 128'(out_last), 128'(0));
        chk("reset_row1", 128'(out_row1), 128'(0));
        chk("reset_seq_err", 128'(seq_err), 128'(0));

        // Known-answer first round, then the rest of the block back to back.
        chk("kat_rk_idx", 128'(rk_idx), 128'(10));
        step(1'b1, 1'b1, 1'b1, 32'h696ad870, 32'hc47bcdb4, 32'he004b7c5, 32'hd830805a);
        chk("kat_valid", 128'(out_valid), 128'(1));
        chk("kat_rows", {out_row1, out_row2, out_row3, out_row4},
            128'h7a892b3d_d5efca9f_fd4e10f5_a7270b9f);
        chk("kat_round", 128'(out_round), 128'(10));
        chk("kat_last", 128'(out_last), 128'(0));
        for (int i = 1; i <= 10; i++) begin
            rstep(1'b1, 1'b0, 1'b1);
            chk("blk_round", 128'(out_round), 128'(10 - i));
            chk("blk_last", 128'(out_last), 128'(i == 10));
            chk("blk_in_ready", 128'(in_ready), 128'(1));
        end
        rstep(1'b0, 1'b0, 1'b1);
        chk("blk_seq_err", 128'(seq_err), 128'(0));
        chk("blk_drained", 128'(out_valid), 128'(0));

        // Backpressure: three stalled cycles while streaming.
        rstep(1'b1, 1'b1, 1'b1);
        rstep(1'b1, 1'b0, 1'b0);
        chk("bp_in_ready0", 128'(in_ready), 128'(0));
        rstep(1'b1, 1'b0, 1'b0);
        chk("bp_in_ready1", 128'(in_ready), 128'(0));
        rstep(1'b1, 1'b0, 1'b0);
        rstep(1'b1, 1'b0, 1'b1);
        chk("bp_in_ready2", 128'(in_ready), 128'(1));
        chk("bp_round", 128'(out_round), 128'(9));
        finish_block();

        // Sequencing errors.
        do_reset();
        rstep(1'b1, 1'b0, 1'b1);
        chk("err_no_out", 128'(out_valid), 128'(0));
        chk("err_sticky", 128'(seq_err), 128'(1));
        rstep(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) rstep(1'b1, 1'b0, 1'b1);
        chk("err_rk5", 128'(rk_idx), 128'(5));
        rstep(1'b1, 1'b1, 1'b1);
        chk("err_restart", 128'(out_round), 128'(10));
        finish_block();

        // Reset mid-block with the skid occupied.
        do_reset();
        rstep(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) rstep(1'b1, 1'b0, 1'b1);
        rstep(1'b1, 1'b0, 1'b0);
        chk("mid_rk4", 128'(rk_idx), 128'(4));
        chk("mid_skid_full", 128'(in_ready), 128'(0));
        do_reset();
        chk("mid_out_valid", 128'(out_valid), 128'(0));
        chk("mid_in_ready", 128'(in_ready), 128'(1));
        rstep(1'b1, 1'b1, 1'b1);
        chk("mid_restart", 128'(out_round), 128'(10));
        finish_block();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++)
            rstep($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0);
        for (int i = 0; i < 4; i++) rstep(1'b0, 1'b0, 1'b1);

`ifdef RKEY_ADD_STAGE_STAT_EN
        do_reset();
        for (int b = 0; b < 3; b++) begin
            rstep(1'b1, 1'b1, 1'b1);
            finish_block();
        end
        chk("stat_three", 128'(blk_cnt), 128'(3));
        force dut.blk_cnt = 16'hFFFF;
        #1 release dut.blk_cnt;
        m_blk = 16'hFFFF;
        rstep(1'b1, 1'b1, 1'b1);
        finish_block();
        chk("stat_sat", 128'(blk_cnt), 128'(16'hFFFF));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
